// File: rtl/ps2_pkg.sv
// +--------------------------------------------------------------------------+
// | ps2_pkg: PS/2 prefix bytes, transmitter state encoding, parity helper.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FRAME = 2'd2,
    ST_GAP   = 2'd3
  } ps2_state_e;

  // odd=0 gives plain XOR of the data, which the in-house receiver checks.
  function automatic logic ps2_parity(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_frame_tx.sv
// +--------------------------------------------------------------------------+
// | ps2_frame_tx: sends one 11-bit PS/2 device-to-host frame for one byte.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 5,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       done,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'd10;

  logic             r_active;
  logic             r_low;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_bit;
  logic [10:0]      r_shift;
  logic             w_half_end;

  assign w_half_end = r_active & (r_div == DIV_LAST);
  assign done       = w_half_end & r_low & (r_bit == BIT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_active <= 1'b0;
      r_low    <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else if (!r_active) begin
      if (start) begin
        // Start bit goes straight onto the line; slot 0 begins this edge.
        r_shift  <= {1'b1, ps2_parity(tx_byte, PARITY_ODD != 0), tx_byte, 1'b0};
        r_active <= 1'b1;
        r_low    <= 1'b0;
        r_div    <= '0;
        r_bit    <= '0;
        ps2_clk  <= 1'b1;
        ps2_data <= 1'b0;
      end
    end else if (w_half_end) begin
      r_div <= '0;
      if (!r_low) begin
        r_low   <= 1'b1;
        ps2_clk <= 1'b0;
      end else begin
        r_low   <= 1'b0;
        ps2_clk <= 1'b1;
        if (r_bit == BIT_LAST) begin
          r_active <= 1'b0;
          ps2_data <= 1'b1;
        end else begin
          r_bit    <= r_bit + 4'd1;
          r_shift  <= {1'b1, r_shift[10:1]};
          ps2_data <= r_shift[1];
        end
      end
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard_tx.sv
// +--------------------------------------------------------------------------+
// | ps2_keyboard_tx: key event handshake, [E0][F0]code byte queue, gap timer. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ps2_keyboard_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 5,
  parameter int GAP_CYCLES = 10,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       key_ext,
  input  logic       key_release,
  output logic       key_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  ps2_state_e       r_state;
  ps2_state_e       w_state_nxt;
  logic [GAP_W-1:0] r_gap;
  logic [7:0]       r_q0;
  logic [7:0]       r_q1;
  logic [1:0]       r_qn;
  logic             w_accept;
  logic             w_gap_end;
  logic             w_pop;
  logic             w_start;
  logic             w_done;
  logic [7:0]       w_first;
  logic [7:0]       w_byte;

  assign key_ready  = (r_state == ST_IDLE);
  assign busy       = ~key_ready;
  assign frame_done = w_done;
  assign w_accept   = key_valid & key_ready;
  assign w_gap_end  = (r_state == ST_GAP) & (r_gap == GAP_LAST);
  assign w_pop      = w_gap_end & (r_qn != 2'd0);
  assign w_first    = key_ext ? PS2_EXT : (key_release ? PS2_BREAK : key_code);

  // The head byte is popped in the accept cycle, so only two entries are stored.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_byte      = r_q0;
    case (r_state)
      ST_IDLE: begin
        if (key_valid) begin
          w_start     = 1'b1;
          w_byte      = w_first;
          w_state_nxt = ST_FRAME;
        end
      end
      ST_LOAD: begin
        w_start     = 1'b1;
        w_state_nxt = ST_FRAME;
      end
      ST_FRAME: begin
        if (w_done) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (w_gap_end) begin
          w_start     = w_pop;
          w_state_nxt = w_pop ? ST_FRAME : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_gap   <= '0;
      r_q0    <= '0;
      r_q1    <= '0;
      r_qn    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= (r_state == ST_GAP) ? r_gap + 1'b1 : '0;
      if (w_accept) begin
        r_q0 <= (key_ext & key_release) ? PS2_BREAK : key_code;
        r_q1 <= key_code;
        r_qn <= {key_ext & key_release, key_ext ^ key_release};
      end else if (w_pop) begin
        r_q0 <= r_q1;
        r_qn <= r_qn - 2'd1;
      end
    end
  end

  ps2_frame_tx #(
    .CLK_DIV    (CLK_DIV),
    .PARITY_ODD (PARITY_ODD)
  ) u_frame (
    .clk      (clk),
    .rstn     (rstn),
    .start    (w_start),
    .tx_byte  (w_byte),
    .done     (w_done),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard_tx.sv
// +--------------------------------------------------------------------------+
// | tb_ps2_keyboard_tx: directed checks of frames, timing, handshake, reset. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ps2_keyboard_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_ext = 1'b0;
  logic       key_release = 1'b0;
  logic       key_ready;
  logic       busy;
  logic       frame_done;
  logic       ps2_clk;
  logic       ps2_data;

  int checks = 0;
  int errors = 0;

  ps2_keyboard_tx dut (
    .clk         (clk),
    .rstn        (rstn),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .key_ready   (key_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data)
  );

  always #5 clk = ~clk;

  // Host-side observer: data sampled on every ps2_clk falling edge.
  int   cyc = 0;
  logic prev_clk = 1'b1;
  bit   bits[$];
  int   fall_cyc[$];
  int   done_cyc[$];
  int   busy_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
      bits.push_back(ps2_data);
      fall_cyc.push_back(cyc);
    end
    prev_clk = ps2_clk;
    if (frame_done === 1'b1) done_cyc.push_back(cyc);
    if (busy === 1'b1) busy_cnt++;
  end

  function automatic logic [10:0] word_at(input int idx);
    logic [10:0] w;
    w = '0;
    for (int i = 0; i < 11; i++)
      if (idx + i < bits.size()) w[i] = bits[idx + i];
    return w;
  endfunction

  task automatic send(input logic [7:0] code, input logic ext, input logic rel,
                      output bit ok);
    @(negedge clk);
    key_code = code; key_ext = ext; key_release = rel; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int edges;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
      errors++; $display("FAIL reset_lines got clk=%b data=%b want 1 1", ps2_clk, ps2_data);
    end
    #1 rstn = 1'b1;
    edges = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ps2_clk !== 1'b1) edges++;
    end
    checks++;
    if (edges !== 0) begin errors++; $display("FAIL reset_idle_clk got %0d low cycles want 0", edges); end
    checks++;
    if (ps2_data !== 1'b1) begin errors++; $display("FAIL reset_data got %b want 1", ps2_data); end
    checks++;
    if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", key_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
  endtask

  task automatic test_make;
    int b0, d0, bc0;
    bit ok;
    logic [10:0] w;
    b0 = bits.size(); d0 = done_cyc.size(); bc0 = busy_cnt;
    send(8'h7D, 1'b0, 1'b0, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL make_timeout got busy=%b want 0", busy); end
    checks++;
    if (bits.size() - b0 !== 11) begin errors++; $display("FAIL make_falls got %0d want 11", bits.size() - b0); end
    w = word_at(b0);
    checks++;
    if (w !== 11'b10011111010) begin errors++; $display("FAIL make_bits got %b want %b", w, 11'b10011111010); end
    checks++;
    if (busy_cnt - bc0 !== 120) begin errors++; $display("FAIL make_busy got %0d want 120", busy_cnt - bc0); end
    checks++;
    if (done_cyc.size() - d0 !== 1) begin errors++; $display("FAIL make_done got %0d want 1", done_cyc.size() - d0); end
  endtask

  task automatic test_break;
    int b0, d0, bc0, gap;
    bit ok;
    logic [10:0] w;
    b0 = bits.size(); d0 = done_cyc.size(); bc0 = busy_cnt;
    send(8'h75, 1'b0, 1'b1, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL break_timeout got busy=%b want 0", busy); end
    checks++;
    if (bits.size() - b0 !== 22) begin errors++; $display("FAIL break_falls got %0d want 22", bits.size() - b0); end
    w = word_at(b0);
    checks++;
    if (w !== 11'b10111100000) begin errors++; $display("FAIL break_f0 got %b want %b", w, 11'b10111100000); end
    w = word_at(b0 + 11);
    checks++;
    if (w !== 11'b11011101010) begin errors++; $display("FAIL break_75 got %b want %b", w, 11'b11011101010); end
    checks++;
    if (busy_cnt - bc0 !== 240) begin errors++; $display("FAIL break_busy got %0d want 240", busy_cnt - bc0); end
    // 10 gap cycles plus 5 high cycles of slot 0 lie between done and next fall.
    gap = (bits.size() >= b0 + 12 && done_cyc.size() > d0) ? fall_cyc[b0 + 11] - done_cyc[d0] : -1;
    checks++;
    if (gap !== 16) begin errors++; $display("FAIL break_gap got %0d want 16", gap); end
  endtask

  task automatic test_ext_release;
    int b0, d0, bc0;
    bit ok;
    logic [10:0] w0, w1, w2;
    b0 = bits.size(); d0 = done_cyc.size(); bc0 = busy_cnt;
    send(8'h11, 1'b1, 1'b1, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL ext_timeout got busy=%b want 0", busy); end
    checks++;
    if (bits.size() - b0 !== 33) begin errors++; $display("FAIL ext_falls got %0d want 33", bits.size() - b0); end
    w0 = word_at(b0); w1 = word_at(b0 + 11); w2 = word_at(b0 + 22);
    checks++;
    if (w0 !== 11'b11111000000) begin errors++; $display("FAIL ext_e0 got %b want %b", w0, 11'b11111000000); end
    checks++;
    if (w1 !== 11'b10111100000) begin errors++; $display("FAIL ext_f0 got %b want %b", w1, 11'b10111100000); end
    checks++;
    if (w2 !== 11'b10000100010) begin errors++; $display("FAIL ext_11 got %b want %b", w2, 11'b10000100010); end
    checks++;
    if (done_cyc.size() - d0 !== 3) begin errors++; $display("FAIL ext_done got %0d want 3", done_cyc.size() - d0); end
    checks++;
    if (busy_cnt - bc0 !== 360) begin errors++; $display("FAIL ext_busy got %0d want 360", busy_cnt - bc0); end
  endtask

  task automatic test_busy_ignore;
    int b0, d0, bc0;
    bit ok;
    logic [10:0] w;
    b0 = bits.size(); d0 = done_cyc.size(); bc0 = busy_cnt;
    @(negedge clk);
    key_code = 8'h1C; key_ext = 1'b0; key_release = 1'b0; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (20) @(negedge clk);
    key_code = 8'h22; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL ignore_timeout got busy=%b want 0", busy); end
    checks++;
    if (bits.size() - b0 !== 11) begin errors++; $display("FAIL ignore_falls got %0d want 11", bits.size() - b0); end
    w = word_at(b0);
    checks++;
    if (w !== 11'b11000111000) begin errors++; $display("FAIL ignore_bits got %b want %b", w, 11'b11000111000); end
    checks++;
    if (busy_cnt - bc0 !== 120) begin errors++; $display("FAIL ignore_busy got %0d want 120", busy_cnt - bc0); end
    checks++;
    if (done_cyc.size() - d0 !== 1) begin errors++; $display("FAIL ignore_done got %0d want 1", done_cyc.size() - d0); end
  endtask

  task automatic test_back_to_back;
    int b0, d0, bc0;
    bit ok;
    logic [10:0] w0, w1;
    b0 = bits.size(); d0 = done_cyc.size(); bc0 = busy_cnt;
    @(negedge clk);
    key_code = 8'h1C; key_ext = 1'b0; key_release = 1'b0; key_valid = 1'b1;
    @(negedge clk);
    key_code = 8'h22;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout got busy=%b want 0", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got busy=%b ready=%b want 1 0", busy, key_ready);
    end
    key_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (bits.size() - b0 !== 22) begin errors++; $display("FAIL b2b_falls got %0d want 22", bits.size() - b0); end
    w0 = word_at(b0); w1 = word_at(b0 + 11);
    checks++;
    if (w0 !== 11'b11000111000 || w1 !== 11'b10001000100) begin
      errors++; $display("FAIL b2b_bits got %b %b want %b %b", w0, w1, 11'b11000111000, 11'b10001000100);
    end
    checks++;
    if (busy_cnt - bc0 !== 240) begin errors++; $display("FAIL b2b_busy got %0d want 240", busy_cnt - bc0); end
    checks++;
    if (done_cyc.size() - d0 !== 2) begin errors++; $display("FAIL b2b_done got %0d want 2", done_cyc.size() - d0); end
  endtask

  task automatic test_reset_mid;
    int b0, d0;
    bit ok;
    logic [10:0] w;
    b0 = bits.size();
    @(negedge clk);
    key_code = 8'h75; key_ext = 1'b0; key_release = 1'b0; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    ok = 1'b0;
    // Sixth fall (start, d0..d4) puts the line in the low half of data bit 4.
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (bits.size() >= b0 + 6) begin ok = 1'b1; break; end
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_timeout got %0d falls want 6", bits.size() - b0); end
    @(negedge clk);
    checks++;
    if (ps2_clk !== 1'b0) begin errors++; $display("FAIL rstmid_pre_clk got %b want 0", ps2_clk); end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
      errors++; $display("FAIL rstmid_lines got clk=%b data=%b want 1 1", ps2_clk, ps2_data);
    end
    checks++;
    if (busy !== 1'b0 || key_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_state got busy=%b ready=%b want 0 1", busy, key_ready);
    end
    #1 rstn = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ps2_clk !== 1'b1) begin
      errors++; $display("FAIL rstmid_no_resume got busy=%b clk=%b want 0 1", busy, ps2_clk);
    end
    b0 = bits.size(); d0 = done_cyc.size();
    send(8'h75, 1'b0, 1'b0, ok);
    checks++;
    if (bits.size() - b0 !== 11 || ok !== 1'b1) begin
      errors++; $display("FAIL rstmid_falls got %0d want 11", bits.size() - b0);
    end
    w = word_at(b0);
    checks++;
    if (w !== 11'b11011101010) begin errors++; $display("FAIL rstmid_bits got %b want %b", w, 11'b11011101010); end
    checks++;
    if (done_cyc.size() - d0 !== 1) begin errors++; $display("FAIL rstmid_done got %0d want 1", done_cyc.size() - d0); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext_release();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_keyboard_tx.md
# ps2_keyboard_tx

Keyboard-side PS/2 transmitter: converts key events (make/break, optionally extended) into PS/2 device-to-host frames on `ps2_clk`/`ps2_data`. It generates the PS/2 clock from the system clock. It is used as the stimulus source for the keyboard receiver block, both in loopback on the BASYS3 board and in simulation. Each accepted event emits a byte sequence: `[E0] [F0] code`.

## Interface
- `CLK_DIV`, 5: system cycles per PS/2 clock half-period (≥1).
- `GAP_CYCLES`, 10: idle cycles (both lines high) after every frame (≥1).
- `PARITY_ODD`, 0: 0 sets the parity bit to `^data`, which the team's receiver expects. 1 sets it to `~^data`, the standard odd parity.
- `clk`  in  1  system clock; all state is on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  an event is offered.
- `key_code`  in  8  scancode.
- `key_ext`  in  1  extended key; prefix the sequence with `E0`.
- `key_release`  in  1  break event; insert `F0` before the code.
- `key_ready`  out  1  high in IDLE; the block accepts an event when `key_valid & key_ready`.
- `busy`  out  1  high from acceptance until return to IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of each frame's stop bit.
- `ps2_clk`  out  1  generated PS/2 clock, registered; idles high.
- `ps2_data`  out  1  PS/2 data, registered; idles high.

## Operation
- Reset values: `ps2_clk`=1, `ps2_data`=1, `key_ready`=1, `busy`=0, `frame_done`=0, state IDLE.
- Reset is asynchronous. Asserting it mid-frame forces the lines high immediately and drops the event; no partial frame resumes.
- On acceptance, `code`, `ext` and `release` are latched into a byte queue of up to 3 entries:
  - `ext`=1 queues `E0`.
  - `release`=1 queues `F0`.
  - `code` is always queued last.
- States and transitions:
  - IDLE → LOAD on accept.
  - LOAD: pop the next byte and build an 11-bit shift word `{1, parity, data[7:0], 0}`, sent LSB first: start bit 0, data LSB first, parity, stop bit 1. Then go to FRAME.
  - FRAME: 11 bit slots, 2·`CLK_DIV` cycles each.
  - GAP: `GAP_CYCLES` cycles, both lines high. Then go to LOAD if the queue is non-empty, otherwise to IDLE.
- Within a bit slot:
  - `ps2_data` updates at slot start.
  - `ps2_clk` is high for the first `CLK_DIV` cycles and low for the second `CLK_DIV` cycles.
  - The data bit is therefore stable for `CLK_DIV` cycles on either side of the falling edge the host samples on.
- `key_valid` offered while busy is ignored. The source must hold it until `key_ready`; there is no buffering of unaccepted events.
- Accept and return-to-IDLE in the same cycle cannot occur: `key_ready` is only high in IDLE.
- Field changes while busy have no effect because the inputs are latched.

## Timing
- Accept at edge N → at edge N+1 the block is in FRAME slot 0 with `ps2_data`=0 (LOAD is merged into the accept cycle and the gap exit).
- The first falling edge of `ps2_clk` occurs `CLK_DIV` cycles after slot start.
- Frame length is 22·`CLK_DIV` cycles. Per byte: 22·`CLK_DIV` + `GAP_CYCLES` (defaults: 120 cycles).
- `frame_done` pulses in the last cycle of the stop-bit low phase.
- `busy` falls and `key_ready` rises on the edge after the last GAP cycle.
- Events take 1, 2 or 3 byte times (defaults: 120, 240 or 360 cycles).
- The divider counter is ⌈log2(`CLK_DIV`)⌉ bits wide and the bit counter is 4 bits, counting 0..10 with no wrap past 10.

## Structure
- Shared package `ps2_pkg`: the constants `PS2_EXT`=8'hE0 and `PS2_BREAK`=8'hF0, the state encoding, and the parity function (the receiver shares both the constants and the parity function).
- One sub-module, `ps2_frame_tx`, sends a single byte: inputs `start` and `byte`; outputs `done`, `ps2_clk`, `ps2_data`; it contains the divider and the shift register. The top level holds the handshake, the byte queue and the GAP timer.

## Test plan
Defaults throughout; the bench samples `ps2_data` on each `ps2_clk` falling edge.
- Reset held, then released: both lines are 1, `key_ready`=1, `busy`=0, and there are no clock edges for 50 cycles.
- Make of 0x7D: exactly 11 falls, sampled 0,1,0,1,1,1,1,1,0,0,1 (parity 0). `busy` is high for 120 cycles; one `frame_done`.
- Break of 0x75: frames `F0` (parity 0) then `75` (parity 1), with a 10-cycle high gap between them; 240 cycles busy.
- Extended release of 0x11: frames `E0` (p=1), `F0` (p=0), `11` (p=0); 3 `frame_done` pulses; 360 cycles.
- `key_valid` asserted for 1 cycle while busy: the event is not sent. The same request held through busy is accepted exactly once, on the cycle `key_ready` rises.
- `rstn` pulsed low during data bit 4: lines go high within the reset cycle. A new 0x75 make then produces a clean frame, and in loopback the receiver shows `scancode`=0x75 and `keyPressed`=1.
